// File: rtl/string_hw_pkg.sv
// Shared constants and enums for the byte-serial string engine.
package string_hw_pkg;

  localparam int unsigned MAX_WORDS = 8;
  localparam int unsigned NBYTES    = 4 * MAX_WORDS;

  typedef enum logic [3:0] {
    OP_LEN     = 4'd0,
    OP_COPY    = 4'd1,
    OP_CONCAT  = 4'd2,
    OP_CMP     = 4'd3,
    OP_UPPER   = 4'd4,
    OP_LOWER   = 4'd5,
    OP_REVERSE = 4'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  // Sub-phase inside RUN: CONCAT walks A then B, REVERSE scans A then writes.
  typedef enum logic [1:0] {
    SCAN_A,
    SCAN_B,
    WRITE
  } phase_e;

endpackage

// File: rtl/string_case_conv.sv
// Combinational ASCII case converter for one byte; non-letters pass through.
module string_case_conv (
  input  logic [7:0] byte_i,
  input  logic       to_upper,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = byte_i;
    if (to_upper && (byte_i >= 8'h61) && (byte_i <= 8'h7A)) begin
      byte_o = byte_i - 8'h20;
    end else if (!to_upper && (byte_i >= 8'h41) && (byte_i <= 8'h5A)) begin
      byte_o = byte_i + 8'h20;
    end
  end

endmodule

// File: rtl/string_op_core.sv
// Byte-serial string engine: LEN, COPY, CONCAT, CMP, UPPER, LOWER, REVERSE at one byte per clock.
// Define STRING_CASE_OPS_EN to build UPPER/LOWER; otherwise indices 4 and 5 are illegal.
module string_op_core #(
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [3:0]              index,
  input  logic [32*MAX_WORDS-1:0] A,
  input  logic [32*MAX_WORDS-1:0] B,
  output logic                    done,
  output logic                    err,
  output logic [32*MAX_WORDS-1:0] Result
);
  import string_hw_pkg::*;

  localparam int unsigned NB   = 4 * MAX_WORDS;
  localparam int unsigned PW   = $clog2(NB);
  localparam int unsigned BW   = 32 * MAX_WORDS;
  localparam logic [PW-1:0] LAST = PW'(NB - 1);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  op_e           op_q, op_d;
  logic [BW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [BW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;

  logic [7:0] a_byte, b_byte, b_at_wr, rev_byte, copy_byte;
  logic       at_last, run_fin;

  function automatic logic op_legal(input logic [3:0] idx);
`ifdef STRING_CASE_OPS_EN
    return idx <= 4'd6;
`else
    return (idx <= 4'd3) || (idx == 4'd6);
`endif
  endfunction

  assign a_byte   = a_q[{wr_q, 3'b000} +: 8];
  assign b_at_wr  = b_q[{wr_q, 3'b000} +: 8];
  assign b_byte   = b_q[{rd_q, 3'b000} +: 8];
  assign rev_byte = a_q[{rd_q, 3'b000} +: 8];
  assign at_last  = (wr_q == LAST);

`ifdef STRING_CASE_OPS_EN
  logic [7:0] conv_byte;

  string_case_conv u_case_conv (
    .byte_i  (a_byte),
    .to_upper(op_q == OP_UPPER),
    .byte_o  (conv_byte)
  );

  always_comb begin
    copy_byte = a_byte;
    if ((op_q == OP_UPPER) || (op_q == OP_LOWER)) copy_byte = conv_byte;
  end
`else
  assign copy_byte = a_byte;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    done_d  = done_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    run_fin = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) state_d = LOAD;
      end

      LOAD: begin
        a_d     = A;
        b_d     = B;
        op_d    = op_e'(index);
        res_d   = '0;
        err_d   = 1'b0;
        wr_d    = '0;
        rd_d    = '0;
        phase_d = SCAN_A;
        if (op_legal(index)) begin
          state_d = RUN;
        end else begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      RUN: begin
        case (op_q)
          OP_LEN: begin
            if ((a_byte == 8'h00) || at_last) begin
              res_d[31:0] = (a_byte == 8'h00) ? 32'(wr_q) : 32'(NB);
              run_fin     = 1'b1;
            end else begin
              wr_d = wr_q + PW'(1);
            end
          end

`ifdef STRING_CASE_OPS_EN
          OP_COPY, OP_UPPER, OP_LOWER: begin
`else
          OP_COPY: begin
`endif
            res_d[{wr_q, 3'b000} +: 8] = copy_byte;
            if ((a_byte == 8'h00) || at_last) run_fin = 1'b1;
            else                              wr_d    = wr_q + PW'(1);
          end

          // A's terminator is detected in the same cycle that B's first byte is
          // taken, so switching from A to B costs no extra clock.
          OP_CONCAT: begin
            if ((phase_q == SCAN_A) && (a_byte != 8'h00) && !at_last) begin
              res_d[{wr_q, 3'b000} +: 8] = a_byte;
              wr_d = wr_q + PW'(1);
            end else begin
              phase_d = SCAN_B;
              if (at_last) begin
                err_d   = (b_byte != 8'h00) || ((phase_q == SCAN_A) && (a_byte != 8'h00));
                run_fin = 1'b1;
              end else begin
                res_d[{wr_q, 3'b000} +: 8] = b_byte;
                if (b_byte == 8'h00) begin
                  run_fin = 1'b1;
                end else begin
                  wr_d = wr_q + PW'(1);
                  rd_d = rd_q + PW'(1);
                end
              end
            end
          end

          OP_CMP: begin
            if (a_byte != b_at_wr) begin
              res_d[31:0] = (a_byte < b_at_wr) ? 32'hFFFF_FFFF : 32'h0000_0001;
              run_fin     = 1'b1;
            end else if ((a_byte == 8'h00) || at_last) begin
              run_fin = 1'b1;
            end else begin
              wr_d = wr_q + PW'(1);
            end
          end

          OP_REVERSE: begin
            if (phase_q == SCAN_A) begin
              if (a_byte == 8'h00) begin
                if (wr_q == '0) begin
                  run_fin = 1'b1;
                end else begin
                  phase_d = WRITE;
                  rd_d    = wr_q - PW'(1);
                  wr_d    = '0;
                end
              end else if (at_last) begin
                phase_d = WRITE;
                rd_d    = LAST;
                wr_d    = '0;
              end else begin
                wr_d = wr_q + PW'(1);
              end
            end else begin
              res_d[{wr_q, 3'b000} +: 8] = rev_byte;
              if (rd_q == '0) begin
                run_fin = 1'b1;
              end else begin
                wr_d = wr_q + PW'(1);
                rd_d = rd_q - PW'(1);
              end
            end
          end

          default: run_fin = 1'b1;
        endcase

        if (run_fin) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (!go) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= SCAN_A;
      op_q    <= OP_LEN;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign Result = res_q;

endmodule

// File: doc/string_op_core.md
# string_op_core

Byte-serial string processing engine behind the Avalon string accelerator register file. Downstream of the register block: it takes the two string buffers A and B, an operation index and a go level, then performs one string operation at one byte per clock. It writes a 32-byte Result buffer and raises done for software to poll through the Control register.

## Interface
Parameters:
- MAX_WORDS, 8, 32-bit words per string buffer; buffer size NBYTES = 4*MAX_WORDS (32).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high. Reset is reset, synchronous, active-high; clock is clk.
- go  in  1  level start request (Control[1]).
- index  in  4  operation select (Control[5:2]).
- A  in  MAX_WORDS x 32  string A, word 0 first.
- B  in  MAX_WORDS x 32  string B.
- done  out  1  operation complete, level.
- err  out  1  illegal op or concat truncation; valid while done=1.
- Result  out  MAX_WORDS x 32  output string or scalar.

## Operation
- Byte order: char k is in word k/4, bits [8*(k%4)+7 : 8*(k%4)], little-endian to match Nios II.
- Strings are null-terminated. If a buffer has no null, len = 32.
- FSM states and transitions:
  - IDLE: go=1 -> LOAD.
  - LOAD, 1 cycle: latch A, B and index into internal copies; clear Result, err, byte pointers. Next state is RUN, or DONE for an illegal index.
  - RUN: one byte per cycle until the op completes -> DONE.
  - DONE: done=1 while go=1; go=0 -> IDLE.
- Inputs are sampled only in LOAD. Changes to A/B/index during RUN are ignored.
- Operations (index):
  - 0 LEN: Result[0] = len(A), range 0..32.
  - 1 COPY: A copied through the null; remaining bytes 0.
  - 2 CONCAT: A then B.
    - If lenA + lenB > 31: output is truncated to 31 chars, byte 31 = 0, and err=1.
  - 3 CMP: unsigned bytewise compare; stop at the first differing byte, a common null, or 32 bytes.
    - Result[0] = 0x00000000 if equal, 0xFFFFFFFF if A<B, 0x00000001 if A>B.
  - 4 UPPER / 5 LOWER: COPY with ASCII a-z to A-Z (or A-Z to a-z); other bytes unchanged.
  - 6 REVERSE: first pass measures lenA, second pass writes the chars reversed. Byte lenA = 0 when lenA < 32.
  - 7-15: illegal. err=1, Result all zero.
- Reset in any state: immediately go to IDLE; done=0, err=0, Result=0, internal copies=0.
- go dropped during LOAD/RUN: the operation completes, done is high for exactly one cycle in DONE, then IDLE.
- Result and err hold after DONE->IDLE until the next LOAD.

## Timing
- Cycle 0 is the edge where go is sampled 1 in IDLE. LOAD executes at cycle 1 and RUN starts at cycle 2.
- done rises after the edge at cycle 1+P, where P is the RUN cycles:
  - LEN/COPY/UPPER/LOWER: P = min(lenA+1, 32).
  - CMP: P = position of stop byte + 1, capped at 32.
  - CONCAT: P = min(lenA, 31) + min(lenB+1, 32 - min(lenA, 31)).
  - REVERSE: P = min(lenA+1, 32) + lenA.
  - Illegal: P = 0 (done after cycle 1).
- Result bytes update in RUN as written. Result is stable and complete when done=1.
- Back-to-back: go held high after DONE does not restart. go must return to 0 for at least one cycle (DONE->IDLE) before a new operation starts.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- STRING_CASE_OPS_EN defined: ops 4 and 5 are implemented as above.
- STRING_CASE_OPS_EN undefined: indices 4 and 5 are illegal (err=1, Result 0, P=0) and the case-conversion logic is absent.

## Structure
- Package string_hw_pkg holds:
  - MAX_WORDS and NBYTES constants.
  - typedef enum op_e: OP_LEN, OP_COPY, OP_CONCAT, OP_CMP, OP_UPPER, OP_LOWER, OP_REVERSE.
  - typedef enum state_e: IDLE, LOAD, RUN, DONE.
  - The RUN sub-phase enum (SCAN_A, SCAN_B, WRITE).
- Sub-module string_case_conv: combinational 8-bit upper/lower converter. It is instantiated only under STRING_CASE_OPS_EN.

## Test plan
- LEN with A = "hello" (word0 0x6C6C6568, word1 0x0000006F): Result[0] = 5, err=0, done rises after cycle 7.
- CONCAT with A = "ab", B = "cd": Result[0] = 0x64636261, Result[1..7] = 0, err=0. With A = 20 x 'x' and B = 20 x 'y': byte 31 = 0 and err=1.
- CMP "abc" vs "abd": Result[0] = 0xFFFFFFFF. CMP "abc" vs "abc": Result[0] = 0. CMP "b" vs "abc": Result[0] = 0x00000001.
- REVERSE with A = "abc": Result[0] = 0x00616263, done after cycle 8. UPPER with A = "aZ1": Result[0] = 0x00315A41, or err=1 when STRING_CASE_OPS_EN is undefined.
- Illegal index 15: err=1, Result = 0, done after cycle 1. With go held high, done stays 1 and there is no restart until go toggles low.
- Reset asserted mid-RUN on a 30-char COPY: next cycle done=0 and Result=0. A new go then completes normally. A write to A during RUN does not alter Result.
